// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, port ids
// and the two-way round-robin pick.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic CORE   = 1'b0;
    localparam logic LOADER = 1'b1;

    // On a tie the port that did not win last time gets the memory.
    function automatic logic rr_pick(
        input logic r0,
        input logic r1,
        input logic last
    );
        if (r0 && r1) begin
            return ~last;
        end
        return r1;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and the
// loader/debug master (port 1) with round-robin and bounded lock.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic          clock,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK);
    // The acquiring IDLE cycle counts as the first owned cycle.
    localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 2);

    arb_state_t    state;
    logic          last;
    logic [CW-1:0] lock_cnt;
    logic          rd_tag;
    logic          rd_pend;

    logic          gnt_any;
    logic          win;
    logic          w_we;
    logic          w_lock;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          own_port;
    logic          own_lock;
    logic          rel;

    always_comb begin
        gnt_any = 1'b0;
        win     = CORE;
        unique case (state)
            IDLE: begin
                gnt_any = p0_req | p1_req;
                win     = rr_pick(p0_req, p1_req, last);
            end
            OWN0: begin
                gnt_any = p0_req;
                win     = CORE;
            end
            OWN1: begin
                gnt_any = p1_req;
                win     = LOADER;
            end
            default: begin
                gnt_any = 1'b0;
                win     = CORE;
            end
        endcase
        if (!rst) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        w_we    = win ? p1_we    : p0_we;
        w_lock  = win ? p1_lock  : p0_lock;
        w_addr  = win ? p1_addr  : p0_addr;
        w_wdata = win ? p1_wdata : p0_wdata;
    end

    assign own_port = (state == OWN1);
    assign own_lock = own_port ? p1_lock : p0_lock;
    assign rel      = !own_lock || (lock_cnt == LOCK_LAST);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            lock_cnt <= '0;
            rd_tag   <= CORE;
            rd_pend  <= 1'b0;
        end else begin
            rd_pend <= gnt_any && !w_we;
            if (gnt_any && !w_we) begin
                rd_tag <= win;
            end
            if (gnt_any) begin
                last <= win;
            end
            unique case (state)
                IDLE: begin
                    if (gnt_any && w_lock) begin
                        state    <= win ? OWN1 : OWN0;
                        lock_cnt <= '0;
                    end
                end
                OWN0, OWN1: begin
                    // Owner keeps priority even if it idles; a waiting
                    // peer wins the first cycle after release.
                    last <= own_port;
                    if (rel) begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    assign p0_gnt    = gnt_any && (win == CORE);
    assign p1_gnt    = gnt_any && (win == LOADER);

    assign mem_re    = gnt_any && !w_we;
    assign mem_we    = gnt_any && w_we;
    assign mem_addr  = gnt_any ? w_addr  : '0;
    assign mem_wdata = gnt_any ? w_wdata : '0;

    assign p0_rvalid = rd_pend && (rd_tag == CORE);
    assign p1_rvalid = rd_pend && (rd_tag == LOADER);
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, read-return scoreboard and
// one task per scenario.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 4;

    logic          clock = 1'b0;
    logic          rst   = 1'b0;
    logic          p0_req, p0_we, p0_lock;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt, p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p1_req, p1_we, p1_lock;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt, p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    exp_t          e;
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] mem [0:255];
    logic          mem_init = 1'b0;
    int            tests = 0;
    int            fails = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
        .clock(clock), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] pat(int i);
        return (i == 16) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(i));
    endfunction

    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            mem_init <= 1'b1;
        end else begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic push(input logic port, input logic [AW-1:0] a);
        exp_t x;
        x.port = port;
        x.data = ref_mem[a[7:0]];
        sbq.push_back(x);
    endtask

    task automatic monitor();
        logic          gp;
        logic [DW-1:0] gd, od;
        forever begin
            @(negedge clock);
            if (p0_rvalid || p1_rvalid) begin
                tests++;
                if (sbq.size() == 0 || (p0_rvalid && p1_rvalid)) begin
                    fails++;
                    $display("FAIL sb_unexpected rvalid=%b%b queued=%0d",
                             p0_rvalid, p1_rvalid, sbq.size());
                end else begin
                    e  = sbq.pop_front();
                    gp = p1_rvalid;
                    gd = p1_rvalid ? p1_rdata : p0_rdata;
                    od = p1_rvalid ? p0_rdata : p1_rdata;
                    if (gp !== e.port || gd !== e.data || od !== '0) begin
                        fails++;
                        $display("FAIL sb_data got port%0d %h other %h, want port%0d %h other 0",
                                 gp, gd, od, e.port, e.data);
                    end
                end
            end
        end
    endtask

    task automatic drain(input string name);
        idle_in();
        @(negedge clock);
        #1;
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL %s_drain %0d reads outstanding, want 0", name, sbq.size());
        end
        sbq.delete();
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        p0_req = 1; p0_addr = 32'h44;
        p1_req = 1; p1_we = 1; p1_addr = 32'h8; p1_wdata = 32'h77;
        @(negedge clock);
        tests++;
        if ({p0_gnt, p1_gnt, mem_re, mem_we, p0_rvalid, p1_rvalid} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 ||
            p0_rdata !== '0 || p1_rdata !== '0) begin
            fails++;
            $display("FAIL reset_outputs gnt=%b%b re=%b we=%b rv=%b%b addr=%h wd=%h, want all 0",
                     p0_gnt, p1_gnt, mem_re, mem_we, p0_rvalid, p1_rvalid, mem_addr, mem_wdata);
        end
        cyc();
        idle_in();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_read();
        p0_req = 1; p0_addr = 32'h10;
        @(negedge clock);
        tests++;
        if ({p0_gnt, p1_gnt, mem_re, mem_we} !== 4'b1010 || mem_addr !== 32'h10) begin
            fails++;
            $display("FAIL read_grant gnt/re/we=%b addr=%h, want 1010 addr 10",
                     {p0_gnt, p1_gnt, mem_re, mem_we}, mem_addr);
        end
        push(0, 32'h10);
        cyc();
        idle_in();
        @(negedge clock);
        tests++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL read_return rv0=%b rd0=%h rv1=%b, want 1 deadbeef 0",
                     p0_rvalid, p0_rdata, p1_rvalid);
        end
        cyc();
        drain("read");
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        do_reset();
        p0_req = 1; p0_addr = 32'h30;
        p1_req = 1; p1_addr = 32'h40;
        for (int i = 0; i < 6; i++) begin
            exp = (i % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clock);
            tests++;
            if ({p0_gnt, p1_gnt} !== exp ||
                mem_addr !== (exp[1] ? 32'h30 : 32'h40)) begin
                fails++;
                $display("FAIL rr_grant cycle %0d gnt=%b addr=%h, want %b",
                         i, {p0_gnt, p1_gnt}, mem_addr, exp);
            end
            push(exp[0], exp[1] ? 32'h30 : 32'h40);
            cyc();
        end
        drain("rr");
    endtask

    task automatic test_lock();
        do_reset();
        p0_req = 1; p0_addr = 32'h50;
        @(negedge clock);
        tests++;
        if (p0_gnt !== 1'b1) begin
            fails++;
            $display("FAIL lock_pre got p0_gnt=%b, want 1", p0_gnt);
        end
        push(0, 32'h50);
        cyc();
        p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 32'h20; p1_wdata = 32'h5A;
        ref_mem[8'h20] = 32'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            tests++;
            if ({p0_gnt, p1_gnt, mem_re, mem_we} !== 4'b0101 ||
                mem_addr !== 32'h20 || mem_wdata !== 32'h5A) begin
                fails++;
                $display("FAIL lock_own cycle %0d gnt/re/we=%b addr=%h wd=%h, want 0101 20 5a",
                         i, {p0_gnt, p1_gnt, mem_re, mem_we}, mem_addr, mem_wdata);
            end
            cyc();
        end
        p1_req = 0; p1_we = 0; p1_lock = 0;
        @(negedge clock);
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            fails++;
            $display("FAIL lock_release_cycle gnt=%b, want 00", {p0_gnt, p1_gnt});
        end
        cyc();
        @(negedge clock);
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL lock_peer_after gnt=%b, want 10", {p0_gnt, p1_gnt});
        end
        push(0, 32'h50);
        cyc();
        p0_req = 0;
        p1_req = 1; p1_addr = 32'h20;
        @(negedge clock);
        tests++;
        if (p1_gnt !== 1'b1 || mem_re !== 1'b1) begin
            fails++;
            $display("FAIL lock_readback gnt1=%b re=%b, want 1 1", p1_gnt, mem_re);
        end
        push(1, 32'h20);
        cyc();
        drain("lock");
    endtask

    task automatic test_timeout();
        logic [1:0] exp;
        do_reset();
        p0_req = 1; p0_lock = 1; p0_addr = 32'h60;
        p1_req = 1; p1_addr = 32'h70;
        for (int c = 1; c <= 10; c++) begin
            exp = ((c - 1) % 5 == 4) ? 2'b01 : 2'b10;
            @(negedge clock);
            tests++;
            if ({p0_gnt, p1_gnt} !== exp) begin
                fails++;
                $display("FAIL timeout_grant cycle %0d gnt=%b, want %b",
                         c, {p0_gnt, p1_gnt}, exp);
            end
            push(exp[0], exp[0] ? 32'h70 : 32'h60);
            cyc();
        end
        drain("timeout");
    endtask

    task automatic test_write();
        do_reset();
        p0_req = 1; p0_we = 1; p0_addr = 32'h80; p0_wdata = 32'h1234_5678;
        ref_mem[8'h80] = 32'h1234_5678;
        @(negedge clock);
        tests++;
        if ({p0_gnt, p1_gnt, mem_re, mem_we} !== 4'b1001 ||
            mem_addr !== 32'h80 || mem_wdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL write_drive gnt/re/we=%b addr=%h wd=%h, want 1001 80 12345678",
                     {p0_gnt, p1_gnt, mem_re, mem_we}, mem_addr, mem_wdata);
        end
        cyc();
        idle_in();
        @(negedge clock);
        tests++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            fails++;
            $display("FAIL write_no_rvalid rv=%b, want 00", {p0_rvalid, p1_rvalid});
        end
        cyc();
        p1_req = 1; p1_addr = 32'h80;
        @(negedge clock);
        tests++;
        if (p1_gnt !== 1'b1) begin
            fails++;
            $display("FAIL write_readback gnt1=%b, want 1", p1_gnt);
        end
        push(1, 32'h80);
        cyc();
        drain("write");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            p0_req = 1; p0_addr = 32'h90 + 32'(i);
            @(negedge clock);
            tests++;
            if (p0_gnt !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 32'h90 + 32'(i)) begin
                fails++;
                $display("FAIL b2b_grant %0d gnt=%b re=%b addr=%h, want 1 1 %h",
                         i, p0_gnt, mem_re, mem_addr, 32'h90 + 32'(i));
            end
            push(0, 32'h90 + 32'(i));
            cyc();
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        p0_req = 1; p0_addr = 32'h10;
        @(negedge clock);
        tests++;
        if (p0_gnt !== 1'b1) begin
            fails++;
            $display("FAIL midrst_grant gnt0=%b, want 1", p0_gnt);
        end
        @(posedge clock);
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_re, mem_we} !== 6'b0 ||
            p0_rdata !== '0 || mem_addr !== '0) begin
            fails++;
            $display("FAIL midrst_outputs gnt=%b%b rv=%b%b re=%b we=%b rd0=%h, want 0",
                     p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_re, mem_we, p0_rdata);
        end
        cyc();
        idle_in();
        rst = 1'b1;
        @(negedge clock);
        tests++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            fails++;
            $display("FAIL midrst_no_rvalid rv=%b, want 00", {p0_rvalid, p1_rvalid});
        end
        cyc();
        p0_req = 1; p0_addr = 32'h10;
        p1_req = 1; p1_addr = 32'h40;
        @(negedge clock);
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL midrst_first_tie gnt=%b, want 10", {p0_gnt, p1_gnt});
        end
        push(0, 32'h10);
        cyc();
        drain("midrst");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        idle_in();
        fork
            monitor();
        join_none
        test_reset();
        test_read();
        test_round_robin();
        test_lock();
        test_timeout();
        test_write();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
